// File: rtl/xdisp_mux.sv
// xdisp_mux -- multiplexed seven-segment display driver.
//
// Converts a signed (two's-complement) or unsigned binary word to BCD with a
// sequential shift-add-3 engine, then scans DIGITS digits at a programmable
// refresh rate. Supports leading-zero blanking, overflow indication and a
// busy/load handshake.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   load      1-cycle strobe, captures data_in when busy=0
//   data_in   value to display (IN_W bits)
//   blank_lz  1 = blank leading zeros of the magnitude (sampled each scan step)
//   busy      high while a conversion is running
//   an        one-hot active-high anode enables, bit 0 = least-significant digit
//   seg       active-low cathodes, bit7..bit1 = a..g, bit0 = dp (always 1)
module xdisp_mux #(
    parameter int DIGITS      = 4,
    parameter int IN_W        = 11,
    parameter int SIGNED      = 1,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [IN_W-1:0]   data_in,
    input  logic              blank_lz,
    output logic              busy,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int MAGD = (SIGNED != 0) ? DIGITS - 1 : DIGITS;
    localparam int BW   = 4 * MAGD;
    localparam int CW   = $clog2(IN_W + 1);
    localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0] SEG_DASH  = 8'b11111101;
    localparam logic [7:0] SEG_BLANK = 8'b11111111;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'b00000011;
            4'd1:    s = 8'b10011111;
            4'd2:    s = 8'b00100101;
            4'd3:    s = 8'b00001101;
            4'd4:    s = 8'b10011001;
            4'd5:    s = 8'b01001001;
            4'd6:    s = 8'b01000001;
            4'd7:    s = 8'b00011111;
            4'd8:    s = 8'b00000001;
            4'd9:    s = 8'b00001001;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < MAGD; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // ---- Stage p0: capture and sign/magnitude split ----
    logic signed [IN_W-1:0] din_s;
    logic signed [IN_W-1:0] din_neg_s;
    logic                   cap_neg;
    logic [IN_W-1:0]        cap_mag;

    assign din_s     = data_in;
    // Negating the most-negative value wraps back to 2^(IN_W-1), which is
    // exactly the wanted magnitude once read as unsigned.
    assign din_neg_s = -din_s;
    assign cap_neg   = (SIGNED != 0) && (din_s < 0);
    assign cap_mag   = cap_neg ? $unsigned(din_neg_s) : data_in;

    logic [BW-1:0]   bcd_p0;
    logic [IN_W-1:0] mag_p0;
    logic            neg_p0;
    logic            ovf_p0;
    logic [CW-1:0]   cnt;

    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_nx;
    logic [IN_W-1:0] mag_nx;
    logic            ovf_nx;

    assign bcd_adj = add3(bcd_p0);
    assign bcd_nx  = {bcd_adj[BW-2:0], mag_p0[IN_W-1]};
    assign mag_nx  = {mag_p0[IN_W-2:0], 1'b0};
    // The bit falling off the top nibble means the value needs more digits.
    assign ovf_nx  = ovf_p0 | bcd_adj[BW-1];

    always_ff @(posedge clk) begin
        if (load && !busy) begin
            bcd_p0 <= '0;
            mag_p0 <= cap_mag;
            neg_p0 <= cap_neg;
            ovf_p0 <= 1'b0;
        end else if (busy) begin
            bcd_p0 <= bcd_nx;
            mag_p0 <= mag_nx;
            ovf_p0 <= ovf_nx;
        end
    end

    // ---- Stage p1: display register, scan counters ----
    logic [BW-1:0] disp_bcd;
    logic          disp_neg;
    logic          disp_ovf;
    logic [PW-1:0] pre;
    logic [IW-1:0] idx;

    logic [MAGD-1:0]   lz_vec;
    logic [3:0]        nib;
    logic              nib_lz;
    logic [7:0]        seg_nx;
    logic [DIGITS-1:0] an_nx;

    // lz_vec[j] = 1 when magnitude digits j and above are all zero.
    always_comb begin
        logic lz;
        lz     = 1'b1;
        lz_vec = '0;
        for (int j = MAGD - 1; j >= 0; j--) begin
            lz        = lz & (disp_bcd[j*4 +: 4] == 4'd0);
            lz_vec[j] = lz;
        end
    end

    always_comb begin
        nib    = 4'd0;
        nib_lz = 1'b0;
        for (int i = 0; i < MAGD; i++) begin
            if (idx == IW'(i)) begin
                nib    = disp_bcd[i*4 +: 4];
                nib_lz = lz_vec[i];
            end
        end

        if (disp_ovf)
            seg_nx = SEG_DASH;
        else if ((SIGNED != 0) && (idx == IW'(DIGITS - 1)))
            seg_nx = disp_neg ? SEG_DASH : SEG_BLANK;
        else if (blank_lz && nib_lz && (idx != '0))
            seg_nx = SEG_BLANK;
        else
            seg_nx = seg_of(nib);

        an_nx = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            disp_ovf <= 1'b0;
            pre      <= '0;
            idx      <= '0;
            an       <= '0;
            seg      <= SEG_BLANK;
        end else begin
            if (load && !busy) begin
                busy <= 1'b1;
                cnt  <= CW'(IN_W);
            end else if (busy) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy     <= 1'b0;
                    disp_bcd <= bcd_nx;
                    disp_neg <= neg_p0;
                    disp_ovf <= ovf_nx;
                end
            end

            if (pre == PW'(REFRESH_DIV - 1)) begin
                pre <= '0;
                an  <= an_nx;
                seg <= seg_nx;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_xdisp_mux.sv
// Testbench for xdisp_mux (DIGITS=4, IN_W=11, SIGNED=1, REFRESH_DIV=4).
// Directed loads with hand-computed segment patterns; expected scan outputs
// are queued by the stimulus process and checked by an independent monitor.
module tb_xdisp_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [10:0] data_in = '0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seg;

    int tests = 0;
    int fails = 0;

    logic [11:0] exp_q[$];
    logic [11:0] e;
    logic [3:0]  prev_an = '0;

    localparam logic [7:0] S0 = 8'b00000011, S1 = 8'b10011111, S2 = 8'b00100101,
                           S3 = 8'b00001101, S4 = 8'b10011001, S5 = 8'b01001001,
                           S7 = 8'b00011111, S9 = 8'b00001001,
                           SD = 8'b11111101, SB = 8'b11111111;

    xdisp_mux #(.DIGITS(4), .IN_W(11), .SIGNED(1), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .blank_lz(blank_lz), .busy(busy), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: each new scan step (an changes to a nonzero value) is compared
    // against the oldest queued expectation, if any is pending.
    always @(negedge clk) begin
        if (an != prev_an && an != 4'b0000 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({an, seg} !== e) begin
                fails++;
                $display("FAIL scan: got an=%b seg=%b, expected an=%b seg=%b",
                         an, seg, e[11:8], e[7:0]);
            end
        end
        prev_an = an;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, s1, s2, s3);
        exp_q.push_back({4'b0001, s0});
        exp_q.push_back({4'b0010, s1});
        exp_q.push_back({4'b0100, s2});
        exp_q.push_back({4'b1000, s3});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Load v; optionally issue a second load (v2) 3 cycles later, which must
    // be ignored. Checks busy rises on the load edge and lasts 11 cycles.
    task automatic do_load(input logic [10:0] v, input bit extra, input logic [10:0] v2);
        int n;
        @(negedge clk);
        check("busy_idle", busy, 0);
        load    = 1'b1;
        data_in = v;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("busy_set", busy, 1);
        n = 1;
        while (busy && n < 40) begin
            if (extra && n == 3) begin
                load    = 1'b1;
                data_in = v2;
            end
            @(posedge clk);
            #1;
            load = 1'b0;
            if (busy) n++;
        end
        check("busy_len", n, 11);
    endtask

    // After the conversion, wait until digit 3 is on so the next scan step
    // is digit 0 from the new display value, then queue the whole frame.
    task automatic expect_frame(input string name, input logic [7:0] s0, s1, s2, s3);
        int n;
        n = 0;
        while (an != 4'b1000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_align"}, an, 4'b1000);
        #1;
        push_frame(s0, s1, s2, s3);
        wait_drain(name);
    endtask

    task automatic run_case(input string name, input logic [10:0] v, input logic blz,
                            input logic [7:0] s0, s1, s2, s3);
        blank_lz = blz;
        do_load(v, 1'b0, 11'd0);
        expect_frame(name, s0, s1, s2, s3);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 4'b0000);
        check("rst_seg", seg, 8'hFF);
        check("rst_busy", busy, 0);
        push_frame(S0, S0, S0, SB);
        exp_q.push_back({4'b0001, S0});
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("first_step_an_early", an, 4'b0000);
        @(posedge clk);
        #1;
        check("first_step_an", an, 4'b0001);
        check("first_step_seg", seg, S0);
        wait_drain("reset_frame");

        run_case("p123",       11'd123,  1'b0, S3, S2, S1, SB);
        run_case("m45",        11'h7D3,  1'b0, S5, S4, S0, SD);
        run_case("m45_lz",     11'h7D3,  1'b1, S5, S4, SB, SD);
        run_case("p999",       11'd999,  1'b0, S9, S9, S9, SB);
        run_case("p1000",      11'd1000, 1'b0, SD, SD, SD, SD);
        run_case("m1024",      11'h400,  1'b0, SD, SD, SD, SD);
        run_case("zero_lz",    11'd0,    1'b1, S0, SB, SB, SB);
        run_case("p105_lz",    11'd105,  1'b1, S5, S0, S1, SB);
        run_case("p7_lz",      11'd7,    1'b1, S7, SB, SB, SB);

        // Second load during conversion is ignored
        blank_lz = 1'b0;
        do_load(11'd77, 1'b1, 11'd500);
        expect_frame("ignore_load", S7, S7, S0, SB);

        // Reset in the middle of a conversion
        blank_lz = 1'b0;
        @(negedge clk);
        load    = 1'b1;
        data_in = 11'd456;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_an", an, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        push_frame(S0, S0, S0, SB);
        wait_drain("midrst_frame");
        check("midrst_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
